// File: rtl/glm_common_pkg.sv
// Shared GLM types and constants: cacheline address type, DMA burst codes,
// the FSM state encoding used by the load/store stages, and staging depth.
package glm_common;

  localparam int unsigned GLM_ADDR_WIDTH       = 42;
  localparam int unsigned GLM_LOG2_MEMORY_SIZE = 10;
  localparam int unsigned GLM_LOG2_STAGE_SIZE  = 6;
  localparam int unsigned STAGE_SIZE           = 1 << GLM_LOG2_STAGE_SIZE;
  localparam int unsigned LINE_WIDTH           = 512;

  typedef logic [GLM_ADDR_WIDTH-1:0] t_claddr;

  // DMA write burst code carried on the first line of a burst
  typedef enum logic [1:0] {
    BURST_1 = 2'b00,
    BURST_2 = 2'b01,
    BURST_4 = 2'b11
  } t_burst;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIGGER = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DONE    = 3'd5
  } t_state;

endpackage

// File: rtl/glm_store_stage.sv
// Staging FIFO for glm_store: 512-bit lines, registered read data
// (1-cycle latency after pop), occupancy count.
// Ports: clk, reset (async active-low), push/wdata, pop/rdata, count.
module glm_store_stage #(
  parameter int unsigned LOG2_DEPTH = 6,
  parameter int unsigned WIDTH      = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [LOG2_DEPTH:0]   count
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned CW    = LOG2_DEPTH + 1;
  localparam int unsigned PW    = LOG2_DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  // storage array, no reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // pointers, count and registered read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rdata <= mem[rptr];
        rptr  <= rptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(pop && count == '0));

endmodule

// File: rtl/glm_store.sv
// GLM store stage: drains lines from a source FIFO or BRAM region into host
// DRAM via the DMA write engine, through a credit-controlled staging FIFO,
// issuing 1/2/4-line bursts; op_done pulses when all lines are accepted and
// the engine is idle.
// Ports: op_start/op_done control; in_*/cfg_* instruction fields; src_fifo_*
// and src_mem_* source interfaces; dma_* write-engine interface;
// perf_stall_cycles backpressure counter.
// Build option: GLM_STORE_PERF_COUNTERS_EN enables perf_stall_cycles
// (otherwise tied to 0).
module glm_store
  import glm_common::*;
#(
  parameter int unsigned ADDR_WIDTH       = GLM_ADDR_WIDTH,
  parameter int unsigned LOG2_MEMORY_SIZE = GLM_LOG2_MEMORY_SIZE,
  parameter int unsigned LOG2_STAGE_SIZE  = GLM_LOG2_STAGE_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        op_start,
  output logic                        op_done,
  input  logic                        in_trigger_dma,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [31:0]                 cfg_dram_offset,
  input  logic [31:0]                 cfg_length,
  input  logic                        cfg_src_sel,
  input  logic [LOG2_MEMORY_SIZE-1:0] cfg_bram_base,
  input  logic                        src_fifo_empty,
  output logic                        src_fifo_re,
  input  logic                        src_fifo_rvalid,
  input  logic [511:0]                src_fifo_rdata,
  output logic                        src_mem_re,
  output logic [LOG2_MEMORY_SIZE-1:0] src_mem_raddr,
  input  logic                        src_mem_rvalid,
  input  logic [511:0]                src_mem_rdata,
  input  logic                        dma_idle,
  input  logic                        dma_active,
  output logic                        dma_start,
  output logic [ADDR_WIDTH-1:0]       dma_addr,
  output logic [31:0]                 dma_length,
  output logic                        dma_we,
  output logic [1:0]                  dma_wlength,
  output logic [511:0]                dma_wdata,
  input  logic                        dma_almostfull,
  output logic [31:0]                 perf_stall_cycles
);

  localparam int unsigned CW    = LOG2_STAGE_SIZE + 1;
  localparam int unsigned STAGE = 1 << LOG2_STAGE_SIZE;
  localparam int unsigned MW    = LOG2_MEMORY_SIZE;

  t_state                fstate, wstate;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [30:0]           len_q, fetched, popped, remaining;
  logic                  ml_q, src_q;
  logic [MW-1:0]         base_q;
  logic [CW-1:0]         in_flight, credit, stage_count;
  logic [1:0]            beats_left;
  logic [511:0]          stage_rdata, ret_data;
  logic                  start_ok, issue, ret;
  logic                  pop, first;
  t_burst                code;
  logic [1:0]            beats;

  assign start_ok = op_start && (fstate == ST_IDLE) && (wstate == ST_IDLE);

  // read issue: credit and length gate, FIFO source also needs data present
  assign issue = (fstate == ST_READ) && (credit != '0) && (fetched < len_q)
                 && (src_q || !src_fifo_empty);
  assign src_fifo_re   = issue && !src_q;
  assign src_mem_re    = issue && src_q;
  assign src_mem_raddr = src_mem_re ? (base_q + fetched[MW-1:0]) : '0;

  // returns with nothing outstanding (e.g. stale after reset) are dropped
  assign ret      = (src_q ? src_mem_rvalid : src_fifo_rvalid) && (in_flight != '0);
  assign ret_data = src_q ? src_mem_rdata : src_fifo_rdata;

  // fetch FSM, instruction latch, credit and in-flight tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fstate    <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      ml_q      <= 1'b0;
      src_q     <= 1'b0;
      base_q    <= '0;
      fetched   <= '0;
      in_flight <= '0;
      credit    <= '0;
    end else begin
      // subtracting this cycle's issue keeps the registered credit conservative
      credit    <= CW'(STAGE) - stage_count - in_flight - CW'(issue);
      in_flight <= in_flight + CW'(issue) - CW'(ret);
      case (fstate)
        ST_IDLE: if (start_ok) begin
          addr_q  <= {in_addr[ADDR_WIDTH-1:32], in_addr[31:0] + cfg_dram_offset};
          len_q   <= cfg_length[30:0];
          ml_q    <= cfg_length[31];
          src_q   <= cfg_src_sel;
          base_q  <= cfg_bram_base;
          fetched <= '0;
          fstate  <= (cfg_length[30:0] == 31'd0) ? ST_DONE : ST_READ;
        end
        ST_READ: if (issue) begin
          fetched <= fetched + 31'd1;
          if (fetched + 31'd1 == len_q) fstate <= ST_DONE;
        end
        default: fstate <= ST_IDLE;
      endcase
    end
  end

  assign remaining = len_q - popped;

  // burst selection; an open burst continues regardless of backpressure
  always_comb begin
    pop   = 1'b0;
    first = 1'b0;
    code  = BURST_1;
    beats = 2'd0;
    if (wstate == ST_WRITE) begin
      if (beats_left != 2'd0) begin
        pop = 1'b1;
      end else if (dma_active && !dma_almostfull && (popped != len_q)) begin
        if (ml_q && remaining >= 31'd4 && stage_count >= CW'(4)) begin
          pop = 1'b1; first = 1'b1; code = BURST_4; beats = 2'd3;
        end else if (ml_q && remaining >= 31'd2 && stage_count >= CW'(2)) begin
          pop = 1'b1; first = 1'b1; code = BURST_2; beats = 2'd1;
        end else if (stage_count != '0) begin
          pop = 1'b1; first = 1'b1; code = BURST_1; beats = 2'd0;
        end
      end
    end
  end

  // write FSM and registered DMA outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstate      <= ST_IDLE;
      popped      <= '0;
      beats_left  <= '0;
      dma_start   <= 1'b0;
      dma_addr    <= '0;
      dma_length  <= '0;
      dma_we      <= 1'b0;
      dma_wlength <= '0;
      op_done     <= 1'b0;
    end else begin
      dma_start   <= 1'b0;
      op_done     <= 1'b0;
      dma_we      <= pop;
      dma_wlength <= first ? code : BURST_1;
      case (wstate)
        ST_IDLE: if (start_ok) begin
          popped     <= '0;
          beats_left <= '0;
          wstate     <= (cfg_length[30:0] == 31'd0) ? ST_DONE
                        : (in_trigger_dma ? ST_TRIGGER : ST_WRITE);
        end
        ST_TRIGGER: if (dma_idle) begin
          dma_start  <= 1'b1;
          dma_addr   <= addr_q;
          dma_length <= {ml_q, len_q};
          wstate     <= ST_WRITE;
        end
        ST_WRITE: if (pop) begin
          popped     <= popped + 31'd1;
          beats_left <= first ? beats : beats_left - 2'd1;
          if (popped + 31'd1 == len_q) wstate <= ST_FLUSH;
        end
        ST_FLUSH: if (dma_idle) wstate <= ST_DONE;
        ST_DONE: begin
          op_done <= 1'b1;
          wstate  <= ST_IDLE;
        end
        default: wstate <= ST_IDLE;
      endcase
    end
  end

  glm_store_stage #(
    .LOG2_DEPTH (LOG2_STAGE_SIZE),
    .WIDTH      (512)
  ) u_stage (
    .clk   (clk),
    .reset (reset),
    .push  (ret),
    .wdata (ret_data),
    .pop   (pop),
    .rdata (stage_rdata),
    .count (stage_count)
  );

  assign dma_wdata = stage_rdata;

`ifdef GLM_STORE_PERF_COUNTERS_EN
  logic [31:0] perf_q;

  // saturating count of WRITE cycles with data staged but the engine blocked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (start_ok) begin
      perf_q <= '0;
    end else if ((wstate == ST_WRITE) && (stage_count != '0)
                 && (dma_almostfull || !dma_active) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_glm_store.sv
// Self-checking bench for glm_store: source FIFO/BRAM models, a DMA write
// engine model, and a scoreboard of expected lines and burst codes.
module tb_glm_store;
  import glm_common::*;

  logic         clk = 1'b0, reset = 1'b0;
  logic         op_start = 1'b0, op_done, in_trigger_dma = 1'b1;
  logic [41:0]  in_addr = '0;
  logic [31:0]  cfg_dram_offset = '0, cfg_length = '0;
  logic         cfg_src_sel = 1'b0;
  logic [9:0]   cfg_bram_base = '0;
  logic         src_fifo_empty, src_fifo_re, src_fifo_rvalid;
  logic [511:0] src_fifo_rdata;
  logic         src_mem_re, src_mem_rvalid;
  logic [9:0]   src_mem_raddr;
  logic [511:0] src_mem_rdata;
  logic         dma_idle, dma_active, dma_start, dma_we;
  logic [41:0]  dma_addr;
  logic [31:0]  dma_length;
  logic [1:0]   dma_wlength;
  logic [511:0] dma_wdata;
  logic         dma_almostfull = 1'b0;
  logic [31:0]  perf_stall_cycles;

  always #5 clk = ~clk;

  glm_store dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done),
    .in_trigger_dma(in_trigger_dma), .in_addr(in_addr),
    .cfg_dram_offset(cfg_dram_offset), .cfg_length(cfg_length),
    .cfg_src_sel(cfg_src_sel), .cfg_bram_base(cfg_bram_base),
    .src_fifo_empty(src_fifo_empty), .src_fifo_re(src_fifo_re),
    .src_fifo_rvalid(src_fifo_rvalid), .src_fifo_rdata(src_fifo_rdata),
    .src_mem_re(src_mem_re), .src_mem_raddr(src_mem_raddr),
    .src_mem_rvalid(src_mem_rvalid), .src_mem_rdata(src_mem_rdata),
    .dma_idle(dma_idle), .dma_active(dma_active), .dma_start(dma_start),
    .dma_addr(dma_addr), .dma_length(dma_length), .dma_we(dma_we),
    .dma_wlength(dma_wlength), .dma_wdata(dma_wdata),
    .dma_almostfull(dma_almostfull), .perf_stall_cycles(perf_stall_cycles)
  );

  int vectors = 0, miscompares = 0;
  int starts_seen = 0, writes_seen = 0, dones_seen = 0;
  logic [511:0] exp_q[$];
  logic [1:0]   exp_code[$];
  logic [9:0]   exp_raddr[$];
  logic [41:0]  exp_addr = '0;
  logic [31:0]  exp_len = '0;
  int fifo_pushed = 0, fifo_popped = 0;
  int act_delay = 0;

  function automatic logic [511:0] line_data(input int i);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = 32'(i) * 32'h9E37_79B1 + 32'(k);
    return r;
  endfunction

  function automatic logic [511:0] mem_line(input logic [9:0] a);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = {6'h2D, 16'(k), a};
    return r;
  endfunction

  // greedy burst pattern assuming the staging FIFO already holds enough lines
  function automatic void push_codes(input int len, input logic ml);
    int rem = len;
    while (rem > 0) begin
      if (ml && rem >= 4) begin exp_code.push_back(2'b11); rem -= 4; end
      else if (ml && rem >= 2) begin exp_code.push_back(2'b01); rem -= 2; end
      else begin exp_code.push_back(2'b00); rem -= 1; end
    end
  endfunction

  // source models: one-cycle read latency, cleared by reset
  assign src_fifo_empty = (fifo_popped >= fifo_pushed);
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_fifo_rvalid <= 1'b0;
      src_mem_rvalid  <= 1'b0;
      src_fifo_rdata  <= '0;
      src_mem_rdata   <= '0;
    end else begin
      src_fifo_rvalid <= src_fifo_re;
      src_mem_rvalid  <= src_mem_re;
      if (src_fifo_re) begin
        src_fifo_rdata <= line_data(fifo_popped);
        fifo_popped    <= fifo_popped + 1;
      end
      if (src_mem_re) src_mem_rdata <= mem_line(src_mem_raddr);
    end
  end

  // DMA engine model: active act_delay cycles after start, idle 3 cycles after last line
  logic eng_active;
  int   eng_pend, eng_wr, eng_tail;
  logic [30:0] eng_len;
  assign dma_active = eng_active;
  assign dma_idle   = !eng_active && (eng_pend == 0);
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_active <= 1'b0; eng_pend <= 0; eng_wr <= 0; eng_tail <= 0; eng_len <= '0;
    end else begin
      if (dma_start) begin
        eng_len <= dma_length[30:0];
        eng_wr  <= 0;
        if (act_delay == 0) eng_active <= 1'b1;
        else eng_pend <= act_delay;
      end else begin
        if (eng_pend != 0) begin
          eng_pend <= eng_pend - 1;
          if (eng_pend == 1) eng_active <= 1'b1;
        end
        if (dma_we) eng_wr <= eng_wr + 1;
        if (eng_active && eng_wr == int'(eng_len)) begin
          if (eng_tail == 2) begin eng_active <= 1'b0; eng_tail <= 0; end
          else eng_tail <= eng_tail + 1;
        end
      end
    end
  end

  // scoreboard monitor, sampling on the falling edge
  initial begin : monitor
    int mon_beats;
    logic [511:0] ed;
    logic [1:0] ec;
    logic [9:0] ea;
    mon_beats = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_beats = 0;
      end else begin
        if (dma_start) begin
          starts_seen++;
          vectors++;
          if ({dma_addr, dma_length} !== {exp_addr, exp_len}) begin
            miscompares++;
            $display("FAIL dma_start_args: got addr=%h len=%h, want addr=%h len=%h",
                     dma_addr, dma_length, exp_addr, exp_len);
          end
        end
        if (src_mem_re) begin
          vectors++;
          if (exp_raddr.size() == 0) begin
            miscompares++;
            $display("FAIL raddr_unexpected: got raddr=%h, want no read", src_mem_raddr);
          end else begin
            ea = exp_raddr.pop_front();
            if (src_mem_raddr !== ea) begin
              miscompares++;
              $display("FAIL raddr: got %h, want %h", src_mem_raddr, ea);
            end
          end
        end
        if (dma_we) begin
          writes_seen++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL wdata_unexpected: got a write, want none");
          end else begin
            ed = exp_q.pop_front();
            if (dma_wdata !== ed) begin
              miscompares++;
              $display("FAIL wdata: got %h, want %h", dma_wdata, ed);
            end
          end
          vectors++;
          if (mon_beats == 0) begin
            ec = (exp_code.size() != 0) ? exp_code.pop_front() : 2'bxx;
            mon_beats = (ec == 2'b11) ? 3 : ((ec == 2'b01) ? 1 : 0);
          end else begin
            ec = 2'b00;
            mon_beats--;
          end
          if (dma_wlength !== ec) begin
            miscompares++;
            $display("FAIL wlength: got %b, want %b", dma_wlength, ec);
          end
        end
        if (op_done) dones_seen++;
      end
    end
  end

  task automatic start_op(input logic [41:0] a, input logic [31:0] off,
                          input logic [31:0] lenf, input logic src, input logic [9:0] base);
    in_addr = a; cfg_dram_offset = off; cfg_length = lenf;
    cfg_src_sel = src; cfg_bram_base = base; in_trigger_dma = 1'b1;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    int k = 0;
    while (dones_seen == d0 && k < budget) begin @(negedge clk); k++; end
    ok = (dones_seen != d0);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++;
    if ({dma_we, dma_start, op_done, src_fifo_re, src_mem_re, dma_wlength,
         dma_addr, dma_length, src_mem_raddr, perf_stall_cycles} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got nonzero control outputs, want 0");
    end
    vectors++;
    if (dma_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_wdata: got %h, want 0", dma_wdata);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dma_we, dma_start, op_done, src_fifo_re, src_mem_re} !== 5'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b, want 00000",
               {dma_we, dma_start, op_done, src_fifo_re, src_mem_re});
    end
  endtask

  task automatic run_and_check(input string name, input int nlines, input int budget);
    int s0 = starts_seen, w0 = writes_seen, d0 = dones_seen;
    bit ok;
    wait_done(d0, budget, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s_timeout: got no op_done, want one", name); end
    vectors++;
    if (starts_seen - s0 != 1 || writes_seen - w0 != nlines || dones_seen - d0 != 1) begin
      miscompares++;
      $display("FAIL %s_counts: got starts=%0d writes=%0d dones=%0d, want 1 %0d 1",
               name, starts_seen - s0, writes_seen - w0, dones_seen - d0, nlines);
    end
    vectors++;
    if (exp_q.size() != 0 || exp_code.size() != 0 || exp_raddr.size() != 0) begin
      miscompares++;
      $display("FAIL %s_leftover: got %0d/%0d/%0d pending, want 0", name,
               exp_q.size(), exp_code.size(), exp_raddr.size());
    end
  endtask

  task automatic test_fifo_single();
    act_delay = 0;
    exp_addr = {10'h2AB, 32'h0000_0008};
    exp_len  = 32'd5;
    for (int k = 0; k < 5; k++) exp_q.push_back(line_data(fifo_popped + k));
    push_codes(5, 1'b0);
    fifo_pushed = fifo_popped + 5;
    start_op({10'h2AB, 32'hFFFF_FFF8}, 32'h10, 32'd5, 1'b0, 10'h0);
    run_and_check("fifo_single", 5, 300);
  endtask

  task automatic test_bram_wrap();
    logic [9:0] a;
    act_delay = 8;
    exp_addr = {10'h001, 32'h0000_1000};
    exp_len  = 32'h8000_0004;
    for (int k = 0; k < 4; k++) begin
      a = 10'h3FE + 10'(k);
      exp_raddr.push_back(a);
      exp_q.push_back(mem_line(a));
    end
    push_codes(4, 1'b1);
    start_op({10'h001, 32'h0000_1000}, 32'h0, 32'h8000_0004, 1'b1, 10'h3FE);
    run_and_check("bram_wrap", 4, 300);
  endtask

  task automatic test_burst_mix();
    act_delay = 8;
    exp_addr = {10'h000, 32'h0000_2020};
    exp_len  = 32'h8000_0007;
    for (int k = 0; k < 7; k++) exp_q.push_back(line_data(fifo_popped + k));
    push_codes(7, 1'b1);
    fifo_pushed = fifo_popped + 7;
    start_op({10'h000, 32'h0000_2000}, 32'h20, 32'h8000_0007, 1'b0, 10'h0);
    run_and_check("burst_mix", 7, 300);
  endtask

  task automatic test_backpressure();
    int w0 = writes_seen, k = 0;
    logic [31:0] exp_perf;
`ifdef GLM_STORE_PERF_COUNTERS_EN
    exp_perf = 32'd20;
`else
    exp_perf = 32'd0;
`endif
    act_delay = 0;
    exp_addr = {10'h155, 32'h0004_0000};
    exp_len  = 32'd200;
    for (int i = 0; i < 200; i++) exp_q.push_back(line_data(fifo_popped + i));
    push_codes(200, 1'b0);
    fifo_pushed = fifo_popped + 200;
    fork
      start_op({10'h155, 32'h0004_0000}, 32'h0, 32'd200, 1'b0, 10'h0);
      begin
        while (writes_seen - w0 < 10 && k < 200) begin @(negedge clk); k++; end
        dma_almostfull = 1'b1;
        repeat (20) @(negedge clk);
        dma_almostfull = 1'b0;
      end
    join_none
    run_and_check("backpressure", 200, 2000);
    vectors++;
    if (perf_stall_cycles !== exp_perf) begin
      miscompares++;
      $display("FAIL perf_stall: got %0d, want %0d", perf_stall_cycles, exp_perf);
    end
  endtask

  task automatic test_zero_len();
    int s0 = starts_seen, w0 = writes_seen;
    logic [2:0] seen;
    in_addr = 42'h123; cfg_length = 32'h8000_0000; cfg_src_sel = 1'b0;
    op_start = 1'b1;
    @(negedge clk); op_start = 1'b0; seen[0] = op_done;
    @(negedge clk); seen[1] = op_done;
    @(negedge clk); seen[2] = op_done;
    vectors++;
    if (seen !== 3'b010) begin
      miscompares++;
      $display("FAIL zero_len_done: got op_done by cycle %b, want 010 (cycle 2 only)", seen);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (starts_seen != s0 || writes_seen != w0) begin
      miscompares++;
      $display("FAIL zero_len_dma: got starts=%0d writes=%0d, want 0 0",
               starts_seen - s0, writes_seen - w0);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = writes_seen, d0, k = 0;
    act_delay = 0;
    exp_addr = {10'h0, 32'h0000_0100};
    exp_len  = 32'd50;
    for (int i = 0; i < 50; i++) exp_q.push_back(line_data(fifo_popped + i));
    push_codes(50, 1'b0);
    fifo_pushed = fifo_popped + 50;
    d0 = dones_seen;
    start_op({10'h0, 32'h0000_0100}, 32'h0, 32'd50, 1'b0, 10'h0);
    while (writes_seen - w0 < 5 && k < 200) begin @(negedge clk); k++; end
    reset = 1'b0;
    #1;
    vectors++;
    if ({dma_we, dma_start, op_done, src_fifo_re, src_mem_re, dma_wlength,
         dma_addr, dma_length, dma_wdata, perf_stall_cycles} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got nonzero outputs, want 0");
    end
    @(negedge clk);
    exp_q.delete(); exp_code.delete();
    fifo_pushed = fifo_popped;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (dones_seen != d0) begin
      miscompares++;
      $display("FAIL mid_reset_done: got %0d op_done, want 0", dones_seen - d0);
    end
    exp_addr = {10'h0, 32'h0000_0203};
    exp_len  = 32'd3;
    for (int i = 0; i < 3; i++) exp_q.push_back(line_data(fifo_popped + i));
    push_codes(3, 1'b0);
    fifo_pushed = fifo_popped + 3;
    start_op({10'h0, 32'h0000_0200}, 32'h3, 32'd3, 1'b0, 10'h0);
    run_and_check("after_reset", 3, 300);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_fifo_single();
    test_bram_wrap();
    test_burst_mix();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want completion within 40000 cycles");
    $fatal(1);
  end

endmodule
